// File: rtl/tmds_pattern_gen.sv
// -----------------------------------------------------------------------------
// tmds_pattern_gen
//   Multi-lane TMDS compliance/test symbol source. Feeds CHANNELS per-lane
//   symbol FIFOs in lockstep with PRBS7, fixed, clock or counter patterns,
//   either as a finite burst or continuously.
//
// Ports
//   clk_i           logic clock
//   reset_n_i       asynchronous active-low reset (synchronously released)
//   enable_i        start / hold a run; dropping it aborts a run
//   mode_i          0=PRBS7 1=fixed 2=clock 3=counter (sampled at start)
//   fixed_symbol_i  symbol used in fixed mode (sampled at start)
//   burst_len_i     symbols per burst, 0 = continuous (sampled at start)
//   fifo_full_i     per-lane FIFO full flags; any one stalls every lane
//   write_o         write strobe shared by all lanes
//   symbols_o       lane c at bits [c*SYMBOL_WIDTH +: SYMBOL_WIDTH]
//   busy_o          run in progress
//   done_o          burst completed, waiting for enable_i to drop
//   symbol_count_o  symbols written in the current / last run
// -----------------------------------------------------------------------------
module tmds_pattern_gen #(
  parameter int         CHANNELS     = 3,
  parameter int         SYMBOL_WIDTH = 10,
  parameter int         COUNT_W      = 16,
  parameter logic [6:0] PRBS_SEED    = 7'h7F
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             enable_i,
  input  logic [1:0]                       mode_i,
  input  logic [SYMBOL_WIDTH-1:0]          fixed_symbol_i,
  input  logic [COUNT_W-1:0]               burst_len_i,
  input  logic [CHANNELS-1:0]              fifo_full_i,
  output logic                             write_o,
  output logic [CHANNELS*SYMBOL_WIDTH-1:0] symbols_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [COUNT_W-1:0]               symbol_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_PRBS  = 2'd0,
    MODE_FIXED = 2'd1,
    MODE_CLOCK = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  // Advance a PRBS7 (x^7+x^6+1) state by SYMBOL_WIDTH bit steps.
  // Returns {next_state, symbol}; symbol bit 0 is the first generated bit.
  function automatic logic [SYMBOL_WIDTH+6:0] prbs_symbol(input logic [6:0] s_in);
    logic [6:0]              s;
    logic [SYMBOL_WIDTH-1:0] sym;
    logic                    b;
    s   = s_in;
    sym = '0;
    for (int i = 0; i < SYMBOL_WIDTH; i++) begin
      b      = s[6] ^ s[5];
      sym[i] = b;
      s      = {s[5:0], b};
    end
    return {s, sym};
  endfunction

  // Lower half ones, upper half zeros: 10'b00000_11111 for TMDS width.
  function automatic logic [SYMBOL_WIDTH-1:0] clock_symbol();
    logic [SYMBOL_WIDTH-1:0] sym;
    for (int i = 0; i < SYMBOL_WIDTH; i++) begin
      sym[i] = (i < SYMBOL_WIDTH / 2);
    end
    return sym;
  endfunction

  localparam logic [SYMBOL_WIDTH-1:0] CLOCK_SYM = clock_symbol();

  // Registered state
  state_e                                r_state;
  mode_e                                 r_mode;
  logic [SYMBOL_WIDTH-1:0]               r_fixed;
  logic [COUNT_W-1:0]                    r_burst;
  logic [COUNT_W-1:0]                    r_count;
  logic [SYMBOL_WIDTH-1:0]               r_idx;      // index of presented symbol
  logic [CHANNELS-1:0][6:0]              r_prbs;     // state after presented symbol
  logic [CHANNELS-1:0][SYMBOL_WIDTH-1:0] r_symbols;

  // Next-symbol datapath
  logic                                  w_start;
  logic                                  w_write;
  mode_e                                 w_src_mode;
  logic [SYMBOL_WIDTH-1:0]               w_src_fixed;
  logic [SYMBOL_WIDTH-1:0]               w_next_idx;
  logic [COUNT_W-1:0]                    w_count_inc;
  logic                                  w_burst_end;
  logic [CHANNELS-1:0][6:0]              w_next_prbs;
  logic [CHANNELS-1:0][SYMBOL_WIDTH-1:0] w_next_syms;

  // In IDLE the first symbol is built from the live inputs and fresh seeds;
  // in RUN the next symbol is built from the values latched at start.
  assign w_start     = (r_state == ST_IDLE);
  assign w_src_mode  = w_start ? mode_e'(mode_i) : r_mode;
  assign w_src_fixed = w_start ? fixed_symbol_i : r_fixed;
  assign w_next_idx  = w_start ? '0 : r_idx + 1'b1;

  // One strobe for every lane so a single full FIFO stalls all of them.
  assign w_write     = (r_state == ST_RUN) && enable_i && !(|fifo_full_i);
  assign w_count_inc = r_count + 1'b1;
  assign w_burst_end = (r_burst != '0) && (w_count_inc == r_burst);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    localparam logic [6:0]              LANE_SEED = PRBS_SEED ^ 7'(c);
    localparam logic [SYMBOL_WIDTH-1:0] LANE_OFF  = SYMBOL_WIDTH'(c);

    logic [6:0]              w_prbs_src;
    logic [SYMBOL_WIDTH+6:0] w_prbs_res;
    logic [SYMBOL_WIDTH-1:0] w_sym;

    assign w_prbs_src     = w_start ? LANE_SEED : r_prbs[c];
    assign w_prbs_res     = prbs_symbol(w_prbs_src);
    assign w_next_prbs[c] = w_prbs_res[SYMBOL_WIDTH+6:SYMBOL_WIDTH];

    // NOTE: the default assignment ahead of the case keeps this block purely
    // combinational; without it a missed branch would infer a latch.
    always_comb begin
      w_sym = '0;
      case (w_src_mode)
        MODE_PRBS:  w_sym = w_prbs_res[SYMBOL_WIDTH-1:0];
        MODE_FIXED: w_sym = w_src_fixed;
        MODE_CLOCK: w_sym = CLOCK_SYM;
        MODE_COUNT: w_sym = w_next_idx + LANE_OFF;
        default:    w_sym = '0;
      endcase
    end

    assign w_next_syms[c] = w_sym;
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates on an edge see the pre-edge values, independent of block order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= ST_IDLE;
      r_mode    <= MODE_PRBS;
      r_fixed   <= '0;
      r_burst   <= '0;
      r_count   <= '0;
      r_idx     <= '0;
      r_symbols <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_prbs[c] <= PRBS_SEED ^ 7'(c);
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable_i) begin
            r_mode    <= mode_e'(mode_i);
            r_fixed   <= fixed_symbol_i;
            r_burst   <= burst_len_i;
            r_count   <= '0;
            r_idx     <= '0;
            r_prbs    <= w_next_prbs;
            r_symbols <= w_next_syms;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable_i) begin
            r_state <= ST_IDLE;
          end else if (w_write) begin
            r_count   <= w_count_inc;
            r_idx     <= w_next_idx;
            r_prbs    <= w_next_prbs;
            r_symbols <= w_next_syms;
            if (w_burst_end) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (!enable_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign write_o        = w_write;
  assign symbols_o      = r_symbols;
  assign busy_o         = (r_state == ST_RUN);
  assign done_o         = (r_state == ST_DONE);
  assign symbol_count_o = r_count;

endmodule

// File: tb/tb_tmds_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_tmds_pattern_gen
//   Directed self-checking bench for tmds_pattern_gen with the default
//   configuration (3 lanes, 10-bit symbols, 16-bit counter, seed 7'h7F).
//   Inputs change 2 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_tmds_pattern_gen;

  localparam int CH = 3;
  localparam int SW = 10;
  localparam int CW = 16;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic             enable_i;
  logic [1:0]       mode_i;
  logic [SW-1:0]    fixed_symbol_i;
  logic [CW-1:0]    burst_len_i;
  logic [CH-1:0]    fifo_full_i;
  logic             write_o;
  logic [CH*SW-1:0] symbols_o;
  logic             busy_o;
  logic             done_o;
  logic [CW-1:0]    symbol_count_o;

  int n_total = 0;
  int n_pass  = 0;

  tmds_pattern_gen dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .enable_i       (enable_i),
    .mode_i         (mode_i),
    .fixed_symbol_i (fixed_symbol_i),
    .burst_len_i    (burst_len_i),
    .fifo_full_i    (fifo_full_i),
    .write_o        (write_o),
    .symbols_o      (symbols_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .symbol_count_o (symbol_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  function automatic logic [SW-1:0] lane(input int c);
    return symbols_o[c*SW +: SW];
  endfunction

  // Reference PRBS7: b = s[6]^s[5], shift left, b enters at bit 0; first bit is symbol bit 0.
  function automatic logic [SW-1:0] ref_prbs(input logic [6:0] s_in, output logic [6:0] s_out);
    logic [SW-1:0] sym;
    logic [6:0]    s;
    s = s_in;
    for (int i = 0; i < SW; i++) begin
      sym[i] = s[6] ^ s[5];
      s      = {s[5:0], sym[i]};
    end
    s_out = s;
    return sym;
  endfunction

  task automatic test_reset();
    if (write_o !== 1'b0) begin $display("FAIL reset_write got=%b exp=0", write_o); end else n_pass++;
    n_total++;
    if (symbols_o !== '0) begin $display("FAIL reset_symbols got=%h exp=0", symbols_o); end else n_pass++;
    n_total++;
    if (symbol_count_o !== '0) begin $display("FAIL reset_count got=%0d exp=0", symbol_count_o); end else n_pass++;
    n_total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      $display("FAIL reset_flags got busy=%b done=%b exp 0/0", busy_o, done_o);
    end else n_pass++;
    n_total++;
  endtask

  // Fixed-mode burst; inputs are scrambled after start to show they are ignored.
  task automatic test_fixed_burst(input logic [CW-1:0] len, input logic [SW-1:0] sym);
    mode_i = 2'd1; fixed_symbol_i = sym; burst_len_i = len; fifo_full_i = '0; enable_i = 1'b1;
    tick();
    fixed_symbol_i = ~sym; mode_i = 2'd3; burst_len_i = 16'd0;
    #1;
    for (int i = 0; i < int'(len) + 3; i++) begin
      n_total++;
      if (write_o !== (i < int'(len))) begin
        $display("FAIL fixed_write[%0d] got=%b exp=%b", i, write_o, (i < int'(len)));
      end else n_pass++;
      if (i < int'(len)) begin
        for (int c = 0; c < CH; c++) begin
          n_total++;
          if (lane(c) !== sym) $display("FAIL fixed_lane%0d[%0d] got=%h exp=%h", c, i, lane(c), sym);
          else n_pass++;
        end
      end
      tick();
    end
    n_total++;
    if (symbol_count_o !== len) $display("FAIL fixed_count got=%0d exp=%0d", symbol_count_o, len);
    else n_pass++;
    n_total++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL fixed_done got done=%b busy=%b exp 1/0", done_o, busy_o);
    else n_pass++;
    enable_i = 1'b0;
    tick();
    n_total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || symbol_count_o !== len) begin
      $display("FAIL fixed_idle got done=%b busy=%b count=%0d exp 0/0/%0d", done_o, busy_o, symbol_count_o, len);
    end else n_pass++;
  endtask

  task automatic test_prbs();
    logic [6:0]    m [CH];
    logic [SW-1:0] e;
    m[0] = 7'h7F; m[1] = 7'h7E; m[2] = 7'h7D;
    mode_i = 2'd0; burst_len_i = 16'd0; fifo_full_i = '0; enable_i = 1'b1;
    tick();
    n_total++;
    if (lane(0) !== 10'h040) $display("FAIL prbs_first_lane0 got=%h exp=040", lane(0));
    else n_pass++;
    for (int i = 0; i < 1000; i++) begin
      n_total++;
      if (write_o !== 1'b1) $display("FAIL prbs_write[%0d] got=%b exp=1", i, write_o);
      else n_pass++;
      for (int c = 0; c < CH; c++) begin
        e = ref_prbs(m[c], m[c]);
        n_total++;
        if (lane(c) !== e) $display("FAIL prbs_lane%0d[%0d] got=%h exp=%h", c, i, lane(c), e);
        else n_pass++;
      end
      tick();
    end
    n_total++;
    if (symbol_count_o !== 16'd1000 || busy_o !== 1'b1) begin
      $display("FAIL prbs_count got=%0d busy=%b exp 1000/1", symbol_count_o, busy_o);
    end else n_pass++;
    enable_i = 1'b0;
    tick();
  endtask

  task automatic test_counter_stall();
    int n;
    n = 0;
    mode_i = 2'd3; burst_len_i = 16'd0; fifo_full_i = '0; enable_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (write_o !== 1'b1 || lane(0) !== 10'(n)) $display("FAIL stall_pre[%0d] got w=%b l0=%h exp 1/%h", i, write_o, lane(0), 10'(n));
      else n_pass++;
      tick(); n++;
    end
    fifo_full_i = 3'b010;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (write_o !== 1'b0) $display("FAIL stall_write[%0d] got=%b exp=0", i, write_o);
      else n_pass++;
      for (int c = 0; c < CH; c++) begin
        n_total++;
        if (lane(c) !== 10'(n + c)) $display("FAIL stall_hold_lane%0d[%0d] got=%h exp=%h", c, i, lane(c), 10'(n + c));
        else n_pass++;
      end
      tick();
    end
    fifo_full_i = '0;
    #1;
    n_total++;
    if (write_o !== 1'b1) $display("FAIL stall_resume_write got=%b exp=1", write_o);
    else n_pass++;
    tick(); n++;
    for (int c = 0; c < CH; c++) begin
      n_total++;
      if (lane(c) !== 10'(n + c)) $display("FAIL stall_resume_lane%0d got=%h exp=%h", c, lane(c), 10'(n + c));
      else n_pass++;
    end
    n_total++;
    if (symbol_count_o !== 16'd4) $display("FAIL stall_count got=%0d exp=4", symbol_count_o);
    else n_pass++;
    enable_i = 1'b0;
    tick();
  endtask

  task automatic test_counter_wrap();
    logic [SW-1:0] e;
    mode_i = 2'd3; burst_len_i = 16'd0; fifo_full_i = '0; enable_i = 1'b1;
    tick();
    for (int n = 0; n < 1030; n++) begin
      n_total++;
      if (write_o !== 1'b1) $display("FAIL wrap_write[%0d] got=%b exp=1", n, write_o);
      else n_pass++;
      for (int c = 0; c < CH; c++) begin
        e = 10'((n + c) % 1024);
        n_total++;
        if (lane(c) !== e) $display("FAIL wrap_lane%0d[%0d] got=%h exp=%h", c, n, lane(c), e);
        else n_pass++;
      end
      if (n == 1023 || n == 1024) begin
        n_total++;
        if (lane(0) !== ((n == 1023) ? 10'h3FF : 10'h000)) $display("FAIL wrap_edge_lane0[%0d] got=%h", n, lane(0));
        else n_pass++;
      end
      if (n == 1021 || n == 1022) begin
        n_total++;
        if (lane(2) !== ((n == 1021) ? 10'h3FF : 10'h000)) $display("FAIL wrap_edge_lane2[%0d] got=%h", n, lane(2));
        else n_pass++;
      end
      tick();
    end
    n_total++;
    if (symbol_count_o !== 16'd1030) $display("FAIL wrap_count got=%0d exp=1030", symbol_count_o);
    else n_pass++;
    enable_i = 1'b0;
    tick();
  endtask

  task automatic test_abort_restart();
    logic [6:0]    s;
    logic [SW-1:0] e;
    mode_i = 2'd2; burst_len_i = 16'd100; fifo_full_i = '0; enable_i = 1'b1;
    tick();
    for (int i = 0; i < 37; i++) begin
      n_total++;
      if (write_o !== 1'b1 || done_o !== 1'b0) $display("FAIL abort_run[%0d] got w=%b done=%b exp 1/0", i, write_o, done_o);
      else n_pass++;
      for (int c = 0; c < CH; c++) begin
        n_total++;
        if (lane(c) !== 10'b0000011111) $display("FAIL clock_lane%0d[%0d] got=%h exp=01f", c, i, lane(c));
        else n_pass++;
      end
      tick();
    end
    enable_i = 1'b0;
    #1;
    n_total++;
    if (write_o !== 1'b0) $display("FAIL abort_write got=%b exp=0", write_o);
    else n_pass++;
    tick();
    n_total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || symbol_count_o !== 16'd37) begin
      $display("FAIL abort_idle got busy=%b done=%b count=%0d exp 0/0/37", busy_o, done_o, symbol_count_o);
    end else n_pass++;
    mode_i = 2'd0; burst_len_i = 16'd0; enable_i = 1'b1;
    tick();
    n_total++;
    if (symbol_count_o !== 16'd0 || busy_o !== 1'b1) $display("FAIL restart_count got=%0d busy=%b exp 0/1", symbol_count_o, busy_o);
    else n_pass++;
    n_total++;
    if (lane(0) !== 10'h040) $display("FAIL restart_lane0 got=%h exp=040", lane(0));
    else n_pass++;
    e = ref_prbs(7'h7E, s);
    n_total++;
    if (lane(1) !== e) $display("FAIL restart_lane1 got=%h exp=%h", lane(1), e);
    else n_pass++;
    e = ref_prbs(7'h7D, s);
    n_total++;
    if (lane(2) !== e) $display("FAIL restart_lane2 got=%h exp=%h", lane(2), e);
    else n_pass++;
    enable_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    mode_i = 2'd1; fixed_symbol_i = 10'h155; burst_len_i = 16'd10; fifo_full_i = '0; enable_i = 1'b1;
    tick(); tick(); tick();
    reset_n_i = 1'b0;
    #1;
    n_total++;
    if (symbols_o !== '0 || write_o !== 1'b0) $display("FAIL midreset_out got sym=%h w=%b exp 0/0", symbols_o, write_o);
    else n_pass++;
    n_total++;
    if (symbol_count_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      $display("FAIL midreset_state got count=%0d busy=%b done=%b exp 0/0/0", symbol_count_o, busy_o, done_o);
    end else n_pass++;
    enable_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (write_o !== 1'b0 || busy_o !== 1'b0 || symbol_count_o !== '0) begin
        $display("FAIL postreset_idle[%0d] got w=%b busy=%b count=%0d exp 0/0/0", i, write_o, busy_o, symbol_count_o);
      end else n_pass++;
    end
  endtask

  initial begin
    reset_n_i      = 1'b0;
    enable_i       = 1'b0;
    mode_i         = 2'd0;
    fixed_symbol_i = '0;
    burst_len_i    = '0;
    fifo_full_i    = '0;
    repeat (2) @(negedge clk_i);
    #1;
    test_reset();
    reset_n_i = 1'b1;
    tick();
    test_reset();
    test_fixed_burst(16'd4, 10'h2AB);
    test_fixed_burst(16'd1, 10'h155);
    test_prbs();
    test_counter_stall();
    test_counter_wrap();
    test_abort_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tmds_pattern_gen.md
Name: tmds_pattern_gen

Overview:
Multi-channel TMDS compliance/test symbol generator, the parametrised successor to the single-lane LFSR pattern source. Drives CHANNELS lanes of SYMBOL_WIDTH-bit symbols into the per-lane symbol FIFOs of the tmds serialiser blocks, in lockstep across lanes. Supports PRBS7, fixed, clock and counter patterns, plus finite bursts or continuous output. Sits in the logic clock domain, downstream of the reset synchroniser.

Parameters:
CHANNELS, 3, number of lanes (1..8)
SYMBOL_WIDTH, 10, bits per symbol (TMDS symbol width)
COUNT_W, 16, width of burst length and symbol counter
PRBS_SEED, 7'h7F, PRBS7 seed for lane 0; lane c seed = PRBS_SEED ^ c (nonzero by construction for CHANNELS<=8 with default seed)

Ports:
clk_i  input  1  logic clock
reset_n_i  input  1  asynchronous active-low reset
enable_i  input  1  start/hold run; low aborts
mode_i  input  2  0=PRBS7, 1=fixed, 2=clock, 3=counter; sampled at start
fixed_symbol_i  input  SYMBOL_WIDTH  symbol for mode 1; sampled at start
burst_len_i  input  COUNT_W  symbols per burst; 0 = continuous; sampled at start
fifo_full_i  input  CHANNELS  per-lane FIFO full flags
write_o  output  1  write strobe, shared by all lanes
symbols_o  output  CHANNELS*SYMBOL_WIDTH  lane c at bits [c*SW +: SW]
busy_o  output  1  state == RUN
done_o  output  1  state == DONE
symbol_count_o  output  COUNT_W  symbols written this run

Behaviour:
- Reset (async assert, sync release): state IDLE; symbols_o=0, symbol_count_o=0, busy_o=0, done_o=0, write_o=0; PRBS states = lane seeds.
- IDLE: on a cycle with enable_i=1, latch mode_i, fixed_symbol_i, burst_len_i; reload PRBS seeds; clear counter; register first symbol of every lane into symbols_o; next state RUN.
- RUN: write_o = enable_i & ~|fifo_full_i (combinational from full/enable; strobe shared so lanes never skew). Any lane full stalls all lanes; symbols_o held stable while stalled.
- On write (write_o=1 at clock edge): symbol_count_o += 1 (wraps mod 2^COUNT_W in continuous mode); symbols_o updates to the next symbol on the same edge, so a new symbol is presented every cycle under no backpressure.
- Burst end: if latched burst_len != 0 and the write brings count to burst_len -> DONE on that edge. burst_len=1 gives exactly one write.
- Abort: enable_i=0 in RUN -> no write that cycle; next state IDLE; symbol_count_o retains its value until next start.
- DONE: write_o=0, done_o=1; stays until enable_i=0, then IDLE. Counter held.
- enable_i held high through DONE->IDLE cannot happen (requires low); new run needs enable_i low for >=1 cycle after DONE.
- Mode changes on mode_i/fixed_symbol_i/burst_len_i during RUN are ignored.
- PRBS7: per-lane 7-bit state s, polynomial x^7+x^6+1. One bit step: b = s[6]^s[5]; s <= {s[5:0], b}. Symbol = 10 consecutive steps, bit 0 = first generated bit. Lane 0, seed 7'h7F, first symbol = 10'h040.
- Fixed: every lane = latched fixed symbol, every write.
- Clock: every lane = 10'b0000011111 (bits 0..4 ones) every write.
- Counter: lane c, n-th symbol (n from 0) = (n + c) mod 2^SYMBOL_WIDTH; wraps 10'h3FF -> 10'h000.

Test Plan:
- Reset, then mode=1, fixed=10'h2AB, burst=4, full=0, enable held -> write_o high exactly 4 consecutive cycles, all lanes 10'h2AB, count=4, done_o=1, busy_o=0.
- Mode=0, burst=0, no backpressure -> lane 0 first symbol 10'h040; all lanes match bit-step reference model for 1000 symbols; lanes 0/1/2 seeds 7F/7E/7D.
- Mode=3, assert fifo_full_i=3'b010 for 5 cycles mid-run -> write_o=0 for those cycles on all lanes, symbols_o frozen; lane 1 resumes exactly n+1 with lanes 0/2 still in lockstep.
- Mode=3, burst=0, run 1030 writes -> lane 0 wraps 10'h3FF->10'h000 at n=1024; lane 2 wraps at n=1022.
- Mode=2, burst=100, drop enable_i after 37 writes -> IDLE next cycle, count=37, done_o never asserted; restart begins at count 0 with fresh seeds.
- Assert reset_n_i low mid-burst (no clock edge) -> outputs zero immediately; after release, IDLE with enable low produces no writes.
